// File: rtl/booth_radix4_mult_8x8.sv
// Sequential signed 8x8 radix-4 Booth multiplier.
// Operands arrive serially on inbus; 17-bit product qualified by a done pulse.
module booth_radix4_mult_8x8 (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        bgn,
  input  logic [7:0]  inbus,
  output logic        done,
  output logic [16:0] outbus
);

  typedef enum logic [2:0] {
    IDLE, LOAD_M, LOAD_Q, ADD, SHIFT, OUTPUT, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  q_q, q_d;
  logic [9:0]  a_q, a_d;
  logic        qm1_q, qm1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [16:0] out_q, out_d;

  logic [9:0]  m_ext, m_dbl, opnd, opnd_x, sum;
  logic        sub;

  assign m_ext = {{2{m_q[7]}}, m_q};
  assign m_dbl = {m_q[7], m_q, 1'b0};

  // A is 10 bits so that -2M with M=-128 (+256) cannot overflow
  always_comb begin
    opnd = '0;
    sub  = 1'b0;
    unique case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: opnd = m_ext;
      3'b011:         opnd = m_dbl;
      3'b100: begin
        opnd = m_dbl;
        sub  = 1'b1;
      end
      3'b101, 3'b110: begin
        opnd = m_ext;
        sub  = 1'b1;
      end
      default: opnd = '0;
    endcase
    opnd_x = sub ? ~opnd : opnd;
    sum    = a_q + opnd_x + {9'd0, sub};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bgn) state_d = LOAD_M;
      end
      LOAD_M: begin
        m_d     = inbus;
        a_d     = '0;
        qm1_d   = 1'b0;
        cnt_d   = '0;
        state_d = LOAD_Q;
      end
      LOAD_Q: begin
        q_d     = inbus;
        state_d = ADD;
      end
      ADD: begin
        a_d     = sum;
        state_d = SHIFT;
      end
      SHIFT: begin
        qm1_d   = q_q[1];
        q_d     = {a_q[1:0], q_q[7:2]};
        a_d     = {{2{a_q[9]}}, a_q[9:2]};
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == 2'd3) ? OUTPUT : ADD;
      end
      OUTPUT: begin
        out_d   = {a_q[8:0], q_q};
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign done   = done_q;
  assign outbus = out_q;

endmodule

// File: tb/tb_booth_radix4_mult_8x8.sv
// Bench for booth_radix4_mult_8x8.
// Random and corner operands against an integer-multiply model.
module tb_booth_radix4_mult_8x8;

  logic        clk;
  logic        rst_b;
  logic        bgn;
  logic [7:0]  inbus;
  logic        done;
  logic [16:0] outbus;

  int checks;
  int failures;
  logic [16:0] last_exp;

  booth_radix4_mult_8x8 dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .bgn    (bgn),
    .inbus  (inbus),
    .done   (done),
    .outbus (outbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [7:0] m,
                                        input logic [7:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[16:0];
  endfunction

  // One complete operation from IDLE; reports product, edge count
  // to done (leaving-IDLE edge = 1), and the cycle after done.
  task automatic do_op(input  logic [7:0]  m,
                       input  logic [7:0]  q,
                       output logic [16:0] res,
                       output int          lat,
                       output logic        done_after,
                       output logic [16:0] out_after);
    @(posedge clk); #1;
    bgn   = 1'b1;
    inbus = m;
    @(posedge clk); #1;
    bgn   = 1'($urandom);
    @(posedge clk); #1;
    inbus = q;
    @(posedge clk); #1;
    inbus = 8'($urandom);
    lat = 3;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      inbus = 8'($urandom);
      lat++;
    end
    bgn = 1'b0;
    res = outbus;
    @(posedge clk); #1;
    done_after = done;
    out_after  = outbus;
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    bgn   = 1'b0;
    inbus = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    checks++;
    if (outbus !== 17'h0) begin
      failures++;
      $display("FAIL reset_outbus got=%h want=00000", outbus);
    end
    last_exp = '0;
  endtask

  task automatic test_directed();
    logic [7:0]  ms [6];
    logic [7:0]  qs [6];
    logic [16:0] ex [6];
    logic [16:0] res, oa;
    logic        da;
    int          lat;
    ms = '{8'h07, 8'h80, 8'h38, 8'h80, 8'h00, 8'hFF};
    qs = '{8'h03, 8'h80, 8'hAD, 8'h7F, 8'hFF, 8'hFF};
    ex = '{17'h00015, 17'h04000, 17'h1EDD8,
           17'h1C080, 17'h00000, 17'h00001};
    for (int i = 0; i < 6; i++) begin
      do_op(ms[i], qs[i], res, lat, da, oa);
      checks++;
      if (res !== ex[i]) begin
        failures++;
        $display("FAIL directed_%0d m=%h q=%h got=%h want=%h",
                 i, ms[i], qs[i], res, ex[i]);
      end
      checks++;
      if (lat !== 12) begin
        failures++;
        $display("FAIL latency_%0d got=%0d want=12", i, lat);
      end
      checks++;
      if (da !== 1'b0 || oa !== ex[i]) begin
        failures++;
        $display("FAIL pulse_hold_%0d done=%b out=%h want done=0 out=%h",
                 i, da, oa, ex[i]);
      end
      last_exp = ex[i];
    end
  endtask

  task automatic test_random();
    logic [7:0]  m, q;
    logic [16:0] res, oa, exp_v;
    logic        da;
    int          lat;
    for (int i = 0; i < 200; i++) begin
      m = 8'($urandom);
      q = 8'($urandom);
      if (i < 8) m = 8'h80;
      do_op(m, q, res, lat, da, oa);
      exp_v = model(m, q);
      checks++;
      if (res !== exp_v || lat !== 12 || da !== 1'b0) begin
        failures++;
        $display("FAIL random m=%h q=%h got=%h lat=%0d want=%h lat=12",
                 m, q, res, lat, exp_v);
      end
      last_exp = exp_v;
    end
  endtask

  // bgn held high: a new operation starts every 13 edges
  task automatic test_back_to_back();
    localparam int N = 100;
    logic [7:0]  ms [N];
    logic [7:0]  qs [N];
    logic [16:0] cur;
    logic        exp_done;
    int          k, ph;
    for (int i = 0; i < N; i++) begin
      ms[i] = 8'($urandom);
      qs[i] = 8'($urandom);
    end
    cur = last_exp;
    @(posedge clk); #1;
    bgn = 1'b1;
    for (int t = 1; t <= 13 * N; t++) begin
      k  = (t - 1) / 13;
      ph = t % 13;
      if (ph == 2)      inbus = ms[k];
      else if (ph == 3) inbus = qs[k];
      else              inbus = 8'($urandom);
      @(posedge clk); #1;
      exp_done = (ph == 12);
      if (exp_done) cur = model(ms[k], qs[k]);
      checks++;
      if (done !== exp_done || outbus !== cur) begin
        failures++;
        $display("FAIL b2b t=%0d done=%b out=%h want done=%b out=%h",
                 t, done, outbus, exp_done, cur);
      end
    end
    bgn = 1'b0;
    last_exp = cur;
  endtask

  task automatic test_mid_reset();
    logic [7:0]  m, q;
    logic [16:0] res, oa, exp_v;
    logic        da;
    int          lat;
    do_op(8'h7F, 8'h81, res, lat, da, oa);
    last_exp = res;
    @(posedge clk); #1;
    bgn   = 1'b1;
    inbus = 8'h55;
    @(posedge clk); #1;
    bgn   = 1'b0;
    @(posedge clk); #1;
    inbus = 8'h66;
    repeat (5) @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    checks++;
    if (done !== 1'b0 || outbus !== 17'h0) begin
      failures++;
      $display("FAIL mid_reset done=%b out=%h want done=0 out=00000",
               done, outbus);
    end
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || outbus !== 17'h0) begin
        failures++;
        $display("FAIL post_reset_idle cyc=%0d done=%b out=%h",
                 i, done, outbus);
      end
    end
    m = 8'($urandom);
    q = 8'($urandom);
    do_op(m, q, res, lat, da, oa);
    exp_v = model(m, q);
    checks++;
    if (res !== exp_v || lat !== 12) begin
      failures++;
      $display("FAIL after_reset m=%h q=%h got=%h lat=%0d want=%h",
               m, q, res, lat, exp_v);
    end
    last_exp = exp_v;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_b    = 1'b1;
    bgn      = 1'b0;
    inbus    = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
